// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage RV32IM core: hazard stalls, branch flush,
// M-extension EX hold and registered EX operand forwarding selects.
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        ex_hold,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] MBUSY = 1'b1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] F7_MEXT    = 7'b0000001;

    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b10;
    localparam logic [1:0] FWD_MWB = 2'b01;

    logic [0:0]    state;
    logic [CW-1:0] cnt;

    logic [4:0] ex_rd, mem_rd;
    logic       ex_regwrite, mem_regwrite;
    logic       ex_memread, mem_memread;

    logic [6:0] id_opcode;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic [6:0] id_f7;
    logic       id_f3_div;
    logic       unused_f3;

    logic       id_uses_rs1, id_uses_rs2, id_wr_class, id_is_load;
    logic       id_writes_rd, id_is_mop;
    logic [CW-1:0] id_mcnt;
    logic       load_use, issue;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    assign id_opcode = id_instr[6:0];
    assign id_rd     = id_instr[11:7];
    assign id_f3_div = id_instr[14];
    assign id_rs1    = id_instr[19:15];
    assign id_rs2    = id_instr[24:20];
    assign id_f7     = id_instr[31:25];
    assign unused_f3 = ^id_instr[13:12];

    always_comb begin
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        id_wr_class = 1'b0;
        id_is_load  = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OPC_LOAD:   begin id_uses_rs1 = 1'b1; id_wr_class = 1'b1; id_is_load = 1'b1; end
                OPC_OPIMM:  begin id_uses_rs1 = 1'b1; id_wr_class = 1'b1; end
                OPC_OP:     begin id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; id_wr_class = 1'b1; end
                OPC_STORE:  begin id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; end
                OPC_BRANCH: begin id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1; end
                OPC_JALR:   begin id_uses_rs1 = 1'b1; id_wr_class = 1'b1; end
                OPC_JAL:    id_wr_class = 1'b1;
                OPC_LUI:    id_wr_class = 1'b1;
                OPC_AUIPC:  id_wr_class = 1'b1;
                default:    ;
            endcase
        end
    end

    assign id_writes_rd = id_wr_class && (id_rd != 5'd0);
    assign id_is_mop    = id_valid && (id_opcode == OPC_OP) && (id_f7 == F7_MEXT);
    assign id_mcnt      = id_f3_div ? DIV_CNT : MUL_CNT;

    // x0 as a load destination never creates a dependency
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (ex_rd == id_rs2)));

    assign issue = (state == RUN) && !ex_branch_taken && !load_use;

    function automatic logic [1:0] fwd_select(
        input logic       used,
        input logic [4:0] rs,
        input logic       exw,
        input logic [4:0] exd,
        input logic       memw,
        input logic [4:0] memd
    );
        if (!used)
            return FWD_RF;
        if (exw && (exd == rs) && (exd != 5'd0))
            return FWD_EXM;
        if (memw && (memd == rs) && (memd != 5'd0))
            return FWD_MWB;
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a_nxt = fwd_select(id_uses_rs1, id_rs1, ex_regwrite, ex_rd, mem_regwrite, mem_rd);
        fwd_b_nxt = fwd_select(id_uses_rs2, id_rs2, ex_regwrite, ex_rd, mem_regwrite, mem_rd);
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        if (reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state == MBUSY) begin
            ex_hold = 1'b1;
        end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            idex_bubble = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= '0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            fwd_a        <= FWD_RF;
            fwd_b        <= FWD_RF;
        end else if (state == MBUSY) begin
            // EX shadow and fwd selects stay with the multi-cycle op; MEM drains
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            cnt          <= cnt - CNT_ONE;
            if (cnt <= CNT_ONE)
                state <= RUN;
        end else begin
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            if (issue) begin
                ex_rd       <= id_rd;
                ex_regwrite <= id_writes_rd;
                ex_memread  <= id_is_load;
                fwd_a       <= fwd_a_nxt;
                fwd_b       <= fwd_b_nxt;
                if (id_is_mop && (id_mcnt != '0)) begin
                    state <= MBUSY;
                    cnt   <= id_mcnt;
                end
            end else begin
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                fwd_a       <= FWD_RF;
                fwd_b       <= FWD_RF;
            end
        end
    end

    logic unused_mem_memread;
    assign unused_mem_memread = mem_memread;

endmodule
